// File: rtl/gsr_pur_assign.sv
// -----------------------------------------------------------------------------
// gsr_pur_assign
//
// Global reset-net generator for the device simulation library. It drives the
// two active-low nets that every primitive reads to build its internal SRN:
//   SRN = GSR_sig & PUR_sig  (primitive GSR = "ENABLED")
//   SRN = PUR_sig            (primitive GSR = "DISABLED")
//
// PUR_sig is held low for PUR_CYCLES edges after reset release and then goes
// high once per reset. GSR_sig follows PUR_sig one edge later. It also
// re-asserts low on every synchronized GSRN request. A stretch counter keeps
// it low for at least GSR_MIN_CYCLES extra edges after the request clears.
//
// Parameters:
//   PUR_CYCLES     (>=1) edges after reset release with PUR_sig low
//   GSR_MIN_CYCLES (>=0) extra low edges on GSR_sig after a request releases
//   SYNC_STAGES    (>=2) depth of the GSRN synchronizer
//
// Ports:
//   CLKI     in   sole clock, rising edge
//   RST      in   synchronous active-high reset
//   GSRN     in   asynchronous global set/reset request, active-low
//   GSR_sig  out  global set/reset net, active-low, registered
//   PUR_sig  out  power-up reset net, active-low, registered
// -----------------------------------------------------------------------------
module gsr_pur_assign #(
    parameter int PUR_CYCLES     = 16,
    parameter int GSR_MIN_CYCLES = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic CLKI,
    input  logic RST,
    input  logic GSRN,
    output logic GSR_sig,
    output logic PUR_sig
);

    localparam int PUR_W = $clog2(PUR_CYCLES + 1);
    // A zero stretch still needs a 1-bit counter so the logic stays uniform.
    localparam int STR_W = (GSR_MIN_CYCLES == 0) ? 1 : $clog2(GSR_MIN_CYCLES + 1);

    localparam logic [PUR_W-1:0] PUR_INIT = PUR_W'(PUR_CYCLES);
    localparam logic [PUR_W-1:0] PUR_ONE  = PUR_W'(1);
    localparam logic [STR_W-1:0] STR_INIT = STR_W'(GSR_MIN_CYCLES);
    localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [PUR_W-1:0]       r_pur_cnt;
    logic [STR_W-1:0]       r_str_cnt;
    logic                   r_pur;
    logic                   r_gsr;
    logic                   w_sync_last;
    logic                   w_str_done;

    // Last synchronizer stage: 0 means a GSR request is active. X/Z on GSRN
    // is carried through unchanged so the library user sees it.
    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_str_done  = (r_str_cnt == '0);

    always_ff @(posedge CLKI) begin
        if (RST) begin
            r_sync    <= '1;
            r_pur_cnt <= PUR_INIT;
            r_str_cnt <= '0;
            r_pur     <= 1'b0;
            r_gsr     <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], GSRN};

            // Power-up countdown: PUR_sig rises on the edge that consumes the
            // last count, then stays high until the next reset.
            if (r_pur_cnt != '0) begin
                r_pur_cnt <= r_pur_cnt - PUR_ONE;
                r_pur     <= (r_pur_cnt == PUR_ONE);
            end else begin
                r_pur     <= 1'b1;
            end

            // Stretch counter reloads on every cycle the request is active,
            // so a retrigger during stretching extends the low period.
            if (!w_sync_last) begin
                r_str_cnt <= STR_INIT;
            end else if (!w_str_done) begin
                r_str_cnt <= r_str_cnt - STR_ONE;
            end

            // GSR is forced low while PUR is low, while a request is active,
            // and while the stretch is still running.
            r_gsr <= r_pur & w_sync_last & w_str_done;
        end
    end

    assign GSR_sig = r_gsr;
    assign PUR_sig = r_pur;

endmodule

// File: tb/tb_gsr_pur_assign.sv
module tb_gsr_pur_assign;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic d_rst, d_gsrn, d_gsr, d_pur;
  // corner-parameter instance
  logic c_rst, c_gsrn, c_gsr, c_pur;

  int checks = 0;
  int errors = 0;
  int e = 0;      // edge index, 0 = last edge with RST=1 (default instance)
  int base = 0;   // edge 0 of the corner instance

  gsr_pur_assign u_def (
    .CLKI    (clk),
    .RST     (d_rst),
    .GSRN    (d_gsrn),
    .GSR_sig (d_gsr),
    .PUR_sig (d_pur)
  );

  gsr_pur_assign #(
    .PUR_CYCLES     (1),
    .GSR_MIN_CYCLES (0),
    .SYNC_STAGES    (3)
  ) u_cor (
    .CLKI    (clk),
    .RST     (c_rst),
    .GSRN    (c_gsrn),
    .GSR_sig (c_gsr),
    .PUR_sig (c_pur)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // run default instance up to edge 'stop', expecting GSR low in [lo,hi]
  task automatic run_to(input string tag, input int stop, input int lo, input int hi);
    while (e < stop) begin
      tick();
      chk({tag, "_gsr"}, d_gsr, !(e >= lo && e <= hi));
      chk({tag, "_pur"}, d_pur, 1'b1);
    end
  endtask

  initial begin
    d_rst = 1'b1; d_gsrn = 1'b1;
    c_rst = 1'b1; c_gsrn = 1'b1;
    repeat (3) tick();
    e = 0;
    chk("rst_pur", d_pur, 1'b0);
    chk("rst_gsr", d_gsr, 1'b0);
    d_rst = 1'b0;

    // power-up: PUR at 16, GSR at 17, then steady high
    while (e < 67) begin
      tick();
      chk("pwr_pur", d_pur, e >= 16);
      chk("pwr_gsr", d_gsr, e >= 17);
    end

    // request latency: low before 100, high before 110 -> GSR low 102..115
    run_to("idle", 99, 1, 0);
    d_gsrn = 1'b0;
    run_to("req", 109, 102, 115);
    d_gsrn = 1'b1;
    run_to("req", 120, 102, 115);

    // one-cycle glitch sampled at edge 131 -> GSR low 133..137
    run_to("idle", 130, 1, 0);
    d_gsrn = 1'b0;
    run_to("glitch", 131, 133, 137);
    d_gsrn = 1'b1;
    run_to("glitch", 140, 133, 137);

    // retrigger: low sampled 150,151, again at 154 -> GSR low 152..160
    run_to("idle", 149, 1, 0);
    d_gsrn = 1'b0;
    run_to("retrig", 151, 152, 160);
    d_gsrn = 1'b1;
    run_to("retrig", 153, 152, 160);
    d_gsrn = 1'b0;
    run_to("retrig", 154, 152, 160);
    d_gsrn = 1'b1;
    run_to("retrig", 165, 152, 160);

    // mid-run reset at edge 200
    run_to("idle", 199, 1, 0);
    d_rst = 1'b1;
    tick();
    chk("mrst_pur", d_pur, 1'b0);
    chk("mrst_gsr", d_gsr, 1'b0);
    d_rst = 1'b0;
    while (e < 220) begin
      tick();
      chk("mrst_pur", d_pur, e >= 216);
      chk("mrst_gsr", d_gsr, e >= 217);
    end

    // corner instance: its last reset edge is edge 220
    base = e;
    chk("cor_rst_pur", c_pur, 1'b0);
    chk("cor_rst_gsr", c_gsr, 1'b0);
    c_rst = 1'b0;
    while (e - base < 5) begin
      tick();
      chk("cor_pwr_pur", c_pur, (e - base) >= 1);
      chk("cor_pwr_gsr", c_gsr, (e - base) >= 2);
    end
    while (e - base < 9) begin
      tick();
      chk("cor_idle_gsr", c_gsr, 1'b1);
    end
    // request before 10 -> low at 13; release before 20 -> high at 23
    c_gsrn = 1'b0;
    while (e - base < 19) begin
      tick();
      chk("cor_req_gsr", c_gsr, !((e - base) >= 13));
      chk("cor_req_pur", c_pur, 1'b1);
    end
    c_gsrn = 1'b1;
    while (e - base < 30) begin
      tick();
      chk("cor_rel_gsr", c_gsr, !((e - base) <= 22));
      chk("cor_rel_pur", c_pur, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
